wb_initiator: RTL

//  Wishbone classic master: initiator-side counterpart of the user-area WB responder (ctrl regs, data/program SRAM windows).

---
 rtl/soomrv_wb_pkg.sv | 22 ++
 rtl/wb_initiator.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/soomrv_wb_pkg.sv
// Shared Wishbone definitions for the initiator: bus widths, FSM state encoding
// and the latched command record.
package soomrv_wb_pkg;

    localparam int WB_SEL_W  = 4;
    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic                 we;
        logic [WB_SEL_W-1:0]  sel;
        logic [WB_DATA_W-1:0] wdata;
    } wb_cmd_t;

endpackage

// File: rtl/wb_initiator.sv
// Wishbone classic initiator: single writes and incrementing read bursts from a
// valid/ready command port, one registered response per beat, per-beat ack timeout.
module wb_initiator
    import soomrv_wb_pkg::*;
#(
    parameter int TIMEOUT     = 255,
    parameter int ADDR_STRIDE = 4,
    parameter int LEN_W       = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [WB_ADDR_W-1:0] cmd_addr,
    input  logic                 cmd_we,
    input  logic [WB_SEL_W-1:0]  cmd_sel,
    input  logic [WB_DATA_W-1:0] cmd_wdata,
    input  logic [LEN_W-1:0]     cmd_len,
    input  logic                 abort,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WB_DATA_W-1:0] rsp_data,
    output logic                 rsp_err,
    output logic                 rsp_last,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic [WB_SEL_W-1:0]  wbm_sel_o,
    output logic [WB_ADDR_W-1:0] wbm_adr_o,
    output logic [WB_DATA_W-1:0] wbm_dat_o,
    input  logic [WB_DATA_W-1:0] wbm_dat_i,
    input  logic                 wbm_ack_i
);

    localparam logic [15:0]          TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [WB_ADDR_W-1:0] STRIDE   = WB_ADDR_W'(ADDR_STRIDE);

    wb_state_e            state_q, state_d;
    logic                 cyc_q, cyc_d;
    logic                 stb_q, stb_d;
    logic                 we_q, we_d;
    logic [WB_SEL_W-1:0]  sel_q, sel_d;
    logic [WB_ADDR_W-1:0] adr_q, adr_d;
    logic [WB_DATA_W-1:0] dat_q, dat_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 rsp_last_q, rsp_last_d;
    logic [WB_DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [LEN_W-1:0]     beats_q, beats_d;
    logic [15:0]          tmo_q, tmo_d;
    wb_cmd_t              cmd_in;

    assign cmd_in    = '{addr: cmd_addr, we: cmd_we, sel: cmd_sel, wdata: cmd_wdata};
    assign cmd_ready = (state_q == ST_IDLE) && !abort;

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_last_d  = rsp_last_q;
        rsp_data_d  = rsp_data_q;
        beats_d     = beats_q;
        tmo_d       = tmo_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d = ST_REQ;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    adr_d   = cmd_in.addr;
                    we_d    = cmd_in.we;
                    sel_d   = cmd_in.sel;
                    dat_d   = cmd_in.wdata;
                    beats_d = cmd_in.we ? '0 : cmd_len;
                    tmo_d   = '0;
                end
            end
            ST_REQ: begin
                // Abort beats everything; an ack beats a timeout landing on the same edge.
                if (abort || (!wbm_ack_i && tmo_q == TMO_LAST)) begin
                    state_d     = ST_RSP;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_last_d  = 1'b1;
                    rsp_data_d  = '0;
                end else if (wbm_ack_i) begin
                    state_d     = ST_RSP;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_last_d  = (beats_q == '0);
                    rsp_data_d  = we_q ? '0 : wbm_dat_i;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            ST_RSP: begin
                if (abort) begin
                    rsp_last_d = 1'b1;
                    cyc_d      = 1'b0;
                end
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_last_q || abort) begin
                        state_d = ST_IDLE;
                        cyc_d   = 1'b0;
                    end else begin
                        state_d = ST_REQ;
                        stb_d   = 1'b1;
                        adr_d   = adr_q + STRIDE;
                        beats_d = beats_q - LEN_W'(1);
                        tmo_d   = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= '0;
            beats_q     <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_last_q  <= rsp_last_d;
            rsp_data_q  <= rsp_data_d;
            beats_q     <= beats_d;
            tmo_q       <= tmo_d;
        end
    end

    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_data  = rsp_data_q;

endmodule
